mem_arbiter: RTL

Shares the single unified instruction/data memory of the multi-cycle RISC-V core between two requesters: port 0 (CPU, instruction fetch and load/store) and port 1 (debug/program loader). One transaction is in flight at a time; a fixed per-transaction sequence is issue, wait, respond. Grant policy is round-robin, optionally fixed-priority. The block sits between the CPU top level and the memory, and returns a one-cycle ack to the winning requester.

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the core's unified memory. It serialises transactions through the
// sequence issue, wait and respond, then returns a one-cycle ack to the port that won.
module mem_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int FIXED_PRIO  = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

  state_t     state_r;
  state_t     state_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_s;
  logic       last_grant_r;
  logic       win_r;
  logic       win_s;
  logic       sel_s;
  logic       any_req_s;
  logic       capture_s;

  assign any_req_s = m0_req | m1_req;
  assign capture_s = (state_r == ST_WAIT) && (cnt_r == 3'd0) && !mem_we;

  // Winner selection and next-state logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    win_s   = win_r;
    sel_s   = 1'b0;
    // A tie goes to port 0 under fixed priority, otherwise to the port that did not win last
    if (m0_req && m1_req) begin
      if (FIXED_PRIO != 0) begin
        sel_s = 1'b0;
      end else begin
        sel_s = ~last_grant_r;
      end
    end else if (m1_req) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_ISSUE;
          win_s   = sel_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_s = ST_WAIT;
        cnt_s   = CNT_LOAD;
      end
      ST_WAIT: begin
        if (cnt_r == 3'd0) begin
          state_s = ST_RESP;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counter, owner and registered control outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 3'd0;
      last_grant_r <= 1'b1;
      win_r        <= 1'b0;
      mem_en       <= 1'b0;
      busy         <= 1'b0;
      grant        <= 2'b00;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      win_r   <= win_s;
      if ((state_r == ST_IDLE) && any_req_s) begin
        last_grant_r <= sel_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
      mem_en <= (state_s == ST_ISSUE);
      busy   <= (state_s != ST_IDLE);
      if (state_s == ST_IDLE) begin
        grant <= 2'b00;
      end else begin
        grant <= win_s ? 2'b10 : 2'b01;
      end
      m0_ack <= (state_s == ST_RESP) && !win_s;
      m1_ack <= (state_s == ST_RESP) && win_s;
    end
  end

  // Winner's request is latched once and drives the memory port for the whole transaction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      mem_we    <= sel_s ? m1_we    : m0_we;
      mem_addr  <= sel_s ? m1_addr  : m0_addr;
      mem_wdata <= sel_s ? m1_wdata : m0_wdata;
    end else begin
      mem_we    <= mem_we;
      mem_addr  <= mem_addr;
      mem_wdata <= mem_wdata;
    end
  end

  // Read data lands in the owner's rdata register and holds until that port's next read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m0_rdata <= 32'd0;
      m1_rdata <= 32'd0;
    end else if (capture_s) begin
      if (win_r) begin
        m1_rdata <= mem_rdata;
      end else begin
        m0_rdata <= mem_rdata;
      end
    end else begin
      m0_rdata <= m0_rdata;
      m1_rdata <= m1_rdata;
    end
  end

endmodule
